// File: rtl/multicycle_datapath.sv
// Multi-cycle RV-subset datapath: one unified memory port, one instruction per
// FETCH..writeback sequence, sticky trap on any unsupported encoding.
module multicycle_datapath #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    input  logic [4:0]      Debug_Source_select,
    output logic [XLEN-1:0] Debug_out,
    output logic [XLEN-1:0] PC,
    output logic [31:0]     Instr,
    output logic            trap
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    // Word-sized access: lw/sw on RV32, ld/sd on RV64.
    localparam logic [2:0] F3_MEM   = (XLEN == 64) ? 3'b011 : 3'b010;

    state_t            state;
    logic [XLEN-1:0]   old_pc, a, b, imm, alu_out, data;
    logic [XLEN-1:0]   rf [32];

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_dec;
    logic        is_r, is_addi, is_load, is_store, is_beq, is_jal;
    state_t      dec_next;
    logic [XLEN-1:0] op2, alu_res;

    assign opcode = Instr[6:0];
    assign rd     = Instr[11:7];
    assign f3     = Instr[14:12];
    assign rs1    = Instr[19:15];
    assign rs2    = Instr[24:20];
    assign f7     = Instr[31:25];

    assign imm_i = {{20{Instr[31]}}, Instr[31:20]};
    assign imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
    assign imm_b = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
    assign imm_j = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};

    always_comb begin
        is_r     = (opcode == OP_R) &&
                   ((f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010)) ||
                    (f7 == 7'h20 && f3 == 3'b000));
        is_addi  = (opcode == OP_IMM)    && (f3 == 3'b000);
        is_load  = (opcode == OP_LOAD)   && (f3 == F3_MEM);
        is_store = (opcode == OP_STORE)  && (f3 == F3_MEM);
        is_beq   = (opcode == OP_BRANCH) && (f3 == 3'b000);
        is_jal   = (opcode == OP_JAL);

        dec_next = TRAP;
        imm_dec  = imm_i;
        if (is_load || is_addi) begin
            dec_next = is_load ? MEMADR : EXEC;
        end else if (is_store) begin
            dec_next = MEMADR;
            imm_dec  = imm_s;
        end else if (is_r) begin
            dec_next = EXEC;
        end else if (is_beq) begin
            dec_next = BEQ;
            imm_dec  = imm_b;
        end else if (is_jal) begin
            dec_next = JAL;
            imm_dec  = imm_j;
        end
    end

    // Immediate form (addi) shares the ALU add path with R-type add.
    always_comb begin
        op2     = (opcode == OP_R) ? b : imm;
        alu_res = a + op2;
        if (opcode == OP_R) begin
            case (f3)
                3'b000:  alu_res = f7[5] ? (a - b) : (a + b);
                3'b111:  alu_res = a & b;
                3'b110:  alu_res = a | b;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                default: alu_res = '0;
            endcase
        end
    end

    assign mem_req   = !reset && (state == FETCH || state == MEMRD || state == MEMWR);
    assign mem_we    = !reset && (state == MEMWR);
    assign mem_addr  = (state == FETCH) ? PC : alu_out;
    assign mem_wdata = b;
    assign Debug_out = (Debug_Source_select == 5'd0) ? '0 : rf[Debug_Source_select];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            PC      <= RESET_PC;
            old_pc  <= '0;
            Instr   <= '0;
            trap    <= 1'b0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            data    <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: if (mem_ready) begin
                    Instr  <= mem_rdata[31:0];
                    old_pc <= PC;
                    PC     <= PC + XLEN'(4);
                    state  <= DECODE;
                end
                DECODE: begin
                    a     <= rf[rs1];
                    b     <= rf[rs2];
                    imm   <= XLEN'($signed(imm_dec));
                    state <= dec_next;
                    if (dec_next == TRAP) trap <= 1'b1;
                end
                MEMADR: begin
                    alu_out <= a + imm;
                    state   <= (opcode == OP_LOAD) ? MEMRD : MEMWR;
                end
                MEMRD: if (mem_ready) begin
                    data  <= mem_rdata;
                    state <= MEMWB;
                end
                MEMWB: begin
                    if (rd != 5'd0) rf[rd] <= data;
                    state <= FETCH;
                end
                MEMWR: if (mem_ready) state <= FETCH;
                EXEC: begin
                    alu_out <= alu_res;
                    state   <= ALUWB;
                end
                ALUWB: begin
                    if (rd != 5'd0) rf[rd] <= alu_out;
                    state <= FETCH;
                end
                BEQ: begin
                    if (a == b) PC <= old_pc + imm;
                    state <= FETCH;
                end
                JAL: begin
                    if (rd != 5'd0) rf[rd] <= old_pc + XLEN'(4);
                    PC    <= old_pc + imm;
                    state <= FETCH;
                end
                TRAP:    state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench: random programs run against an instruction-level model; memory side
// responds with random stalls, checks fetch/store traffic, latency and registers.
module tb_multicycle_datapath;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_req, mem_we, mem_ready;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata, Debug_out, PC;
    logic [4:0]      Debug_Source_select;
    logic [31:0]     Instr;
    logic            trap;

    multicycle_datapath #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .Debug_Source_select(Debug_Source_select),
        .Debug_out(Debug_out), .PC(PC), .Instr(Instr), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_e;
    typedef struct {
        kind_e kind;
        int    rd;
        int    rs1;
        int    rs2;
        int    imm;
    } ins_t;

    ins_t        prog [64];
    logic [31:0] env_mem [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] st_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] encode(input ins_t i);
        logic [31:0] im;
        logic [4:0]  rd, r1, r2;
        im = i.imm;
        rd = 5'(i.rd);
        r1 = 5'(i.rs1);
        r2 = 5'(i.rs2);
        case (i.kind)
            K_ADD:  return {7'h00, r2, r1, 3'b000, rd, 7'h33};
            K_SUB:  return {7'h20, r2, r1, 3'b000, rd, 7'h33};
            K_AND:  return {7'h00, r2, r1, 3'b111, rd, 7'h33};
            K_OR:   return {7'h00, r2, r1, 3'b110, rd, 7'h33};
            K_SLT:  return {7'h00, r2, r1, 3'b010, rd, 7'h33};
            K_ADDI: return {im[11:0], r1, 3'b000, rd, 7'h13};
            K_LW:   return {im[11:0], r1, 3'b010, rd, 7'h03};
            K_SW:   return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
            K_BEQ:  return {im[12], im[10:5], r2, r1, 3'b000, im[4:1], im[11], 7'h63};
            K_JAL:  return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
            default: return 32'h0000007F;
        endcase
    endfunction

    function automatic int lat(input kind_e k);
        case (k)
            K_LW:         return 5;
            K_BEQ, K_JAL: return 3;
            default:      return 4;
        endcase
    endfunction

    task automatic wr(input int rd, input logic [31:0] v);
        if (rd != 0) m_regs[rd] = v;
    endtask

    // Architectural effect of one instruction on the model state.
    task automatic step(input ins_t i, output bit is_ld, output logic [31:0] ld_a);
        logic [31:0] a, b, nxt, ea;
        a = m_regs[i.rs1];
        b = m_regs[i.rs2];
        nxt = m_pc + 32'd4;
        ea = a + i.imm;
        is_ld = 1'b0;
        ld_a = '0;
        case (i.kind)
            K_ADD:  wr(i.rd, a + b);
            K_SUB:  wr(i.rd, a - b);
            K_AND:  wr(i.rd, a & b);
            K_OR:   wr(i.rd, a | b);
            K_SLT:  wr(i.rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            K_ADDI: wr(i.rd, ea);
            K_LW: begin
                wr(i.rd, m_mem[ea[9:2]]);
                is_ld = 1'b1;
                ld_a = ea;
            end
            K_SW: begin
                m_mem[ea[9:2]] = b;
                st_q.push_back(ea);
                st_q.push_back(b);
            end
            K_BEQ:  if (a == b) nxt = m_pc + i.imm;
            K_JAL: begin
                wr(i.rd, m_pc + 32'd4);
                nxt = m_pc + i.imm;
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic set_ins(input int idx, input kind_e k, input int rd, input int rs1,
                           input int rs2, input int imm);
        prog[idx].kind = k;
        prog[idx].rd = rd;
        prog[idx].rs1 = rs1;
        prog[idx].rs2 = rs2;
        prog[idx].imm = imm;
    endtask

    // Forward-only control flow and a trailing illegal word guarantee termination.
    task automatic gen_random(input int n);
        for (int k = 0; k < n - 1; k++) begin
            int r, lim;
            r = $urandom_range(0, 9);
            lim = (n - 1 - k < 3) ? n - 1 - k : 3;
            set_ins(k, kind_e'(r < 5 ? r : 5), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), 0);
            case (r)
                5: prog[k].imm = int'($urandom_range(0, 4095)) - 2048;
                6, 7: begin
                    prog[k].kind = (r == 6) ? K_LW : K_SW;
                    prog[k].rs1 = 0;
                    prog[k].imm = 512 + 4 * int'($urandom_range(0, 31));
                end
                8: begin
                    prog[k].kind = K_BEQ;
                    if ($urandom_range(0, 1) == 1) prog[k].rs2 = prog[k].rs1;
                    prog[k].imm = 4 * int'($urandom_range(1, lim));
                end
                9: begin
                    prog[k].kind = K_JAL;
                    prog[k].imm = 4 * int'($urandom_range(1, lim));
                end
                default: ;
            endcase
        end
        set_ins(n - 1, K_ILL, 0, 0, 0, 0);
    endtask

    task automatic load_mem(input int n);
        for (int w = 0; w < 256; w++) begin
            env_mem[w] = (w < n) ? encode(prog[w]) : $urandom;
            m_mem[w] = env_mem[w];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req", mem_req, 0);
            chk("rst_we", mem_we, 0);
        end
        reset = 1'b0;
        Debug_Source_select = 5'($urandom_range(1, 31));
        #1;
        chk("rst_pc", PC, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_trap", trap, 0);
        chk("rst_dbg", Debug_out, 0);
        m_pc = '0;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        st_q.delete();
    endtask

    task automatic run_prog(input bit stall_en);
        int          t0, stall_cnt, lat_prev, tlat;
        bit          have_prev, pend_load, fetched_prev, done, rdy, seen;
        logic [31:0] ld_addr, exp_instr, sa, sd;
        ins_t        cur;
        have_prev = 0; pend_load = 0; fetched_prev = 0; done = 0;
        t0 = 0; stall_cnt = 0; lat_prev = 0; ld_addr = '0; exp_instr = '0;
        do_reset();
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            if (fetched_prev) chk("instr", Instr, exp_instr);
            fetched_prev = 0;
            rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            mem_ready = rdy;
            mem_rdata = env_mem[mem_addr[9:2]];
            if (mem_req && !rdy) stall_cnt++;
            if (mem_req && rdy) begin
                if (mem_we) begin
                    if (st_q.size() < 2) begin
                        chk("st_unexpected", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        sa = st_q.pop_front();
                        sd = st_q.pop_front();
                        chk("st_addr", mem_addr, sa);
                        chk("st_data", mem_wdata, sd);
                    end
                    env_mem[mem_addr[9:2]] = mem_wdata;
                end else if (pend_load) begin
                    chk("ld_addr", mem_addr, ld_addr);
                    pend_load = 0;
                end else begin
                    chk("fetch_addr", mem_addr, m_pc);
                    chk("pc", PC, m_pc);
                    if (have_prev) chk("latency", cyc - t0, lat_prev + stall_cnt);
                    Debug_Source_select = 5'($urandom_range(1, 7));
                    #1;
                    chk("dbg", Debug_out, m_regs[Debug_Source_select]);
                    t0 = cyc; stall_cnt = 0; have_prev = 1;
                    cur = prog[m_pc[7:2]];
                    exp_instr = encode(cur);
                    lat_prev = lat(cur.kind);
                    if (cur.kind == K_ILL) done = 1;
                    else begin
                        fetched_prev = 1;
                        step(cur, pend_load, ld_addr);
                    end
                end
            end else if (mem_req && !mem_we && !pend_load) begin
                chk("stall_addr", mem_addr, m_pc);
                chk("stall_pc", PC, m_pc);
            end
        end
        chk("prog_done", done, 1);
        seen = 0; tlat = 0;
        for (int j = 1; j <= 8 && !seen; j++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            if (j == 1) chk("instr_ill", Instr, 32'h0000007F);
            if (trap) begin seen = 1; tlat = j; end
        end
        chk("trap_lat", tlat, 2);
        chk("trap_pc", PC, m_pc + 32'd4);
        repeat (3) begin
            @(negedge clk);
            chk("trap_req", mem_req, 0);
            chk("trap_hold", trap, 1);
        end
        for (int s = 0; s < 32; s++) begin
            Debug_Source_select = 5'(s);
            #1;
            chk("reg_sweep", Debug_out, m_regs[s]);
        end
        chk("st_left", st_q.size(), 0);
    endtask

    task automatic reset_in_memrd();
        bit found;
        found = 0;
        set_ins(0, K_ADDI, 5, 0, 0, 9);
        set_ins(1, K_LW, 6, 0, 0, 512);
        set_ins(2, K_ILL, 0, 0, 0, 0);
        load_mem(3);
        do_reset();
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            mem_rdata = env_mem[mem_addr[9:2]];
            if (mem_req && !mem_we && mem_addr == 32'd512) found = 1;
            else mem_ready = 1'b1;
        end
        chk("memrd_seen", found, 1);
        mem_ready = 1'b0;
        Debug_Source_select = 5'd5;
        #1;
        chk("pre_x5", Debug_out, 9);
        repeat (2) begin
            @(negedge clk);
            chk("memrd_hold_req", mem_req, 1);
            chk("memrd_hold_addr", mem_addr, 512);
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("memrd_rst_req", mem_req, 0);
        reset = 1'b0;
        Debug_Source_select = 5'd6;
        #1;
        chk("memrd_x6", Debug_out, 0);
        chk("memrd_pc", PC, 0);
        chk("memrd_fetch_addr", mem_addr, 0);
        chk("memrd_fetch_we", mem_we, 0);
        chk("memrd_fetch_req", mem_req, 1);
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        Debug_Source_select = '0;
        m_pc = '0;

        set_ins(0, K_ADDI, 1, 0, 0, 5);
        set_ins(1, K_JAL, 0, 0, 0, 12);
        set_ins(2, K_JAL, 3, 0, 0, 12);
        set_ins(3, K_ILL, 0, 0, 0, 0);
        set_ins(4, K_BEQ, 0, 1, 1, -8);
        set_ins(5, K_SW, 0, 0, 1, 512);
        set_ins(6, K_LW, 2, 0, 0, 512);
        set_ins(7, K_ILL, 0, 0, 0, 0);
        load_mem(8);
        run_prog(1'b0);

        repeat (3) begin
            gen_random(40);
            load_mem(40);
            run_prog(1'b1);
        end

        reset_in_memrd();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter: XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter: RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: mem_req  output  1  memory access request.
REQ-006 Port: mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 Port: mem_addr  output  XLEN  byte address of access.
REQ-008 Port: mem_wdata  output  XLEN  store data.
REQ-009 Port: mem_rdata  input  XLEN  load/fetch data, valid when mem_ready=1.
REQ-010 Port: mem_ready  input  1  access completes on a cycle where mem_req=1 and mem_ready=1.
REQ-011 Port: Debug_Source_select  input  5  register index for debug read.
REQ-012 Port: Debug_out  output  XLEN  combinational read of register Debug_Source_select; x0 reads 0.
REQ-013 Port: PC  output  XLEN  current PC register.
REQ-014 Port: Instr  output  32  instruction register.
REQ-015 Port: trap  output  1  sticky illegal-instruction flag.

Function
REQ-016 Single unified memory port; one instruction per multi-cycle sequence; internal FSM, no external control inputs.
REQ-017 Supported: add, sub, and, or, slt (R); addi (I); lw (XLEN=32) / ld (XLEN=64); sw / sd; beq; jal. Other opcodes are illegal.
REQ-018 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, JAL, TRAP.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on handshake Instr<=mem_rdata, OldPC<=PC, PC<=PC+4, go DECODE; else hold, outputs stable.
REQ-020 DECODE: read rs1/rs2 into A/B latches, sign-extend immediate (I, S, B, J formats); lw/sw -> MEMADR; R/addi -> EXEC; beq -> BEQ; jal -> JAL; illegal -> TRAP.
REQ-021 MEMADR: ALUOut<=A+imm; load -> MEMRD, store -> MEMWR.
REQ-022 MEMRD: mem_req=1, mem_we=0, mem_addr=ALUOut; on handshake Data<=mem_rdata, go MEMWB; else hold.
REQ-023 MEMWB: rd<=Data, go FETCH.
REQ-024 MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B; on handshake go FETCH; else hold.
REQ-025 EXEC: ALUOut<=op(A, B or imm), go ALUWB; ALUWB: rd<=ALUOut, go FETCH.
REQ-026 BEQ: if A==B then PC<=OldPC+immB; go FETCH.
REQ-027 JAL: rd<=OldPC+4, PC<=OldPC+immJ; go FETCH.
REQ-028 TRAP: trap=1, mem_req=0, absorbing until reset.
REQ-029 Writes to x0 discarded; x0 always reads 0.
REQ-030 Arithmetic modulo 2^XLEN; slt signed; no overflow detection.
REQ-031 mem_req=0 in all states except FETCH, MEMRD, MEMWR.
REQ-032 Latency with mem_ready tied 1: R/addi 4 cycles, lw 5, sw 4, beq 3, jal 3.
REQ-033 Register file writes in MEMWB/ALUWB/JAL visible on Debug_out the following cycle.

Reset
REQ-034 reset=1 on a rising edge: state<=FETCH, PC<=RESET_PC, Instr<=0, trap<=0, all 32 registers<=0, internal latches<=0.
REQ-035 Reset overrides any in-flight access; an uncompleted memory handshake is abandoned, no register write occurs.
REQ-036 During reset cycle outputs: mem_req=0, mem_we=0.

Verification
REQ-037 Reset, mem_ready=1, addi x1,x0,5 at 0 -> after 4 cycles Debug_out(sel=1)=5, PC=4.
REQ-038 sw x1,8(x0) then lw x2,8(x0) -> mem write addr 8 data 5; Debug_out(sel=2)=5 after load completes.
REQ-039 mem_ready held 0 for 3 cycles in FETCH -> mem_req=1, mem_addr constant, PC unchanged until handshake.
REQ-040 beq x1,x1,-8 at PC=16 -> next fetch address 8; jal x3,12 at PC=8 -> x3=12, next fetch 20.
REQ-041 Opcode 0x7F fetched -> trap=1 from TRAP entry onward, mem_req=0; reset clears trap, PC=RESET_PC.
REQ-042 Reset asserted during MEMRD wait -> no register update, next state FETCH at RESET_PC.
